// File: rtl/bus_fifo.sv
// Memory-mapped FIFO slave on the PS-to-PL register bus.
// Supports word push/pop through DATA, occupancy/status reads, and an incrementing-pattern fill source.
module bus_fifo #(
  parameter logic [15:0] BASE       = 16'h0100,
  parameter int unsigned DEPTH_LOG2 = 9
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] baddr,
  input  logic [15:0] bwrdata,
  input  logic        bwr,
  input  logic        bstrobe,
  output logic [15:0] brddata,
  output logic        empty,
  output logic        full
);

  typedef enum logic [2:0] {
    REG_CSR     = 3'd0,
    REG_DATA    = 3'd1,
    REG_COUNT   = 3'd2,
    REG_PATTERN = 3'd3,
    REG_ID      = 3'd4,
    REG_RSVD5   = 3'd5,
    REG_RSVD6   = 3'd6,
    REG_RSVD7   = 3'd7
  } reg_off_e;

  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [15:0]           mem_q [1 << DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  pat_en_q, pat_en_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic [15:0]           pattern_q, pattern_d;
  logic [15:0]           brddata_q, brddata_d;

  logic        sel, wr_acc, rd_acc, is_empty, is_full;
  logic        flush, bus_push_req, bus_push, pop_req, pop, pat_push, push;
  logic [15:0] push_data;
  reg_off_e    off;

  always_comb begin
    sel          = (baddr[15:3] == BASE[15:3]);
    off          = reg_off_e'(baddr[2:0]);
    wr_acc       = bstrobe & bwr & sel;
    rd_acc       = bstrobe & ~bwr & sel;
    is_empty     = (count_q == '0);
    is_full      = (count_q == FULL_CNT);
    flush        = wr_acc && (off == REG_CSR) && bwrdata[0];
    bus_push_req = wr_acc && (off == REG_DATA);
    pop_req      = rd_acc && (off == REG_DATA);
    pop          = pop_req && !is_empty;
    // A pop frees the slot, so a bus push into a full FIFO is accepted when it coincides with one.
    bus_push     = bus_push_req && (!is_full || pop);
    pat_push     = !flush && pat_en_q && !is_full && !bus_push_req;
    push         = bus_push || pat_push;
    push_data    = bus_push ? bwrdata : pattern_q;
  end

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    pat_en_d  = pat_en_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    pattern_d = pattern_q;
    brddata_d = '0;

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (DEPTH_LOG2+1)'(1);
        2'b01:   count_d = count_q - (DEPTH_LOG2+1)'(1);
        default: count_d = count_q;
      endcase
    end

    if (bus_push_req && !bus_push) ovf_d = 1'b1;
    if (pop_req && is_empty)       unf_d = 1'b1;

    if (wr_acc && (off == REG_CSR)) begin
      pat_en_d = bwrdata[1];
      if (bwrdata[2]) ovf_d = 1'b0;
      if (bwrdata[3]) unf_d = 1'b0;
    end

    if (wr_acc && (off == REG_PATTERN)) pattern_d = bwrdata;
    else if (pat_push)                  pattern_d = pattern_q + 16'd1;

    if (sel) begin
      case (off)
        REG_CSR:     brddata_d = {12'h000, unf_q, ovf_q, pat_en_q, 1'b0};
        REG_DATA:    brddata_d = is_empty ? 16'h0000 : mem_q[rd_ptr_q];
        REG_COUNT:   brddata_d = 16'(count_q);
        REG_PATTERN: brddata_d = pattern_q;
        REG_ID:      brddata_d = 16'hF1F0;
        default:     brddata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      pat_en_q  <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      pattern_q <= '0;
      brddata_q <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      pat_en_q  <= pat_en_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      pattern_q <= pattern_d;
      brddata_q <= brddata_d;
    end
  end

  assign brddata = brddata_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);

endmodule

// File: tb/tb_bus_fifo.sv
// Bench for bus_fifo: directed vector table, hand-written corner sequences and random bus traffic,
// all cross-checked every cycle against a queue-based reference model.
module tb_bus_fifo;
  localparam logic [15:0] BASE  = 16'h0100;
  localparam int          DEPTH = 512;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] baddr = '0;
  logic [15:0] bwrdata = '0;
  logic        bwr = 1'b0;
  logic        bstrobe = 1'b0;
  logic [15:0] brddata;
  logic        empty, full;

  bus_fifo #(.BASE(BASE), .DEPTH_LOG2(9)) dut (
    .clk(clk), .rst_n(rst_n), .baddr(baddr), .bwrdata(bwrdata), .bwr(bwr),
    .bstrobe(bstrobe), .brddata(brddata), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] q[$];
  logic [15:0] m_pat;
  logic        m_pat_en, m_ovf, m_unf;

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
    string       name;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    if (a[15:3] != BASE[15:3]) return 16'h0000;
    case (a[2:0])
      3'd0:    return {12'h000, m_unf, m_ovf, m_pat_en, 1'b0};
      3'd1:    return (q.size() > 0) ? q[0] : 16'h0000;
      3'd2:    return 16'(q.size());
      3'd3:    return m_pat;
      3'd4:    return 16'hF1F0;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step(input logic s, input logic w, input logic [15:0] a, input logic [15:0] d);
    bit sel, wr_acc, rd_acc, flush, bpush, pop_req, did_pop, was_full, bus_ok, pat_push;
    logic [2:0] off;
    sel      = (a[15:3] == BASE[15:3]);
    off      = a[2:0];
    wr_acc   = s && w && sel;
    rd_acc   = s && !w && sel;
    was_full = (q.size() == DEPTH);
    flush    = wr_acc && off == 3'd0 && d[0];
    bpush    = wr_acc && off == 3'd1;
    pop_req  = rd_acc && off == 3'd1;
    did_pop  = pop_req && q.size() > 0;
    bus_ok   = bpush && (!was_full || did_pop);
    pat_push = !flush && m_pat_en && !was_full && !bpush;
    if (pop_req && q.size() == 0) m_unf = 1'b1;
    if (bpush && !bus_ok) m_ovf = 1'b1;
    if (flush) q.delete();
    else begin
      if (did_pop) void'(q.pop_front());
      if (bus_ok) q.push_back(d);
      else if (pat_push) q.push_back(m_pat);
    end
    if (wr_acc && off == 3'd3) m_pat = d;
    else if (pat_push) m_pat = m_pat + 16'd1;
    if (wr_acc && off == 3'd0) begin
      m_pat_en = d[1];
      if (d[2]) m_ovf = 1'b0;
      if (d[3]) m_unf = 1'b0;
    end
  endtask

  task automatic cycle(input logic s, input logic w, input logic [15:0] a, input logic [15:0] d);
    logic [15:0] exp_rd;
    bstrobe = s; bwr = w; baddr = a; bwrdata = d;
    exp_rd = m_read(a);
    m_step(s, w, a, d);
    @(posedge clk); #1;
    chk("brddata", brddata, exp_rd);
    chk("empty", 16'(empty), 16'(q.size() == 0));
    chk("full", 16'(full), 16'(q.size() == DEPTH));
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
    cycle(1'b0, 1'b1, a, d);
    cycle(1'b0, 1'b1, a, d);
    cycle(1'b1, 1'b1, a, d);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
    cycle(1'b0, 1'b0, a, 16'h0000);
    cycle(1'b0, 1'b0, a, 16'h0000);
    d = brddata;
    cycle(1'b1, 1'b0, a, 16'h0000);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; bstrobe = 1'b0; bwr = 1'b0;
    @(posedge clk); #1;
    q.delete(); m_pat = '0; m_pat_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    chk("rst_brddata", brddata, 16'h0000);
    chk("rst_empty", 16'(empty), 16'h0001);
    chk("rst_full", 16'(full), 16'h0000);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] rd;
    logic [15:0] a, d;
    int cyc;

    tbl.push_back('{1'b0, 16'h0100, 16'h0000, 16'h0000, "csr_reset"});
    tbl.push_back('{1'b0, 16'h0102, 16'h0000, 16'h0000, "count_reset"});
    tbl.push_back('{1'b0, 16'h0104, 16'h0000, 16'hF1F0, "id"});
    tbl.push_back('{1'b0, 16'h0200, 16'h0000, 16'h0000, "outside"});
    tbl.push_back('{1'b0, 16'h0105, 16'h0000, 16'h0000, "rsvd5"});
    tbl.push_back('{1'b1, 16'h0101, 16'h1234, 16'h0000, ""});
    tbl.push_back('{1'b1, 16'h0101, 16'hABCD, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0102, 16'h0000, 16'h0002, "count2"});
    tbl.push_back('{1'b0, 16'h0101, 16'h0000, 16'h1234, "pop1"});
    tbl.push_back('{1'b0, 16'h0102, 16'h0000, 16'h0001, "count1"});
    tbl.push_back('{1'b0, 16'h0101, 16'h0000, 16'hABCD, "pop2"});
    tbl.push_back('{1'b0, 16'h0102, 16'h0000, 16'h0000, "count0"});
    tbl.push_back('{1'b0, 16'h0101, 16'h0000, 16'h0000, "pop_empty"});
    tbl.push_back('{1'b0, 16'h0100, 16'h0000, 16'h0008, "csr_unf"});
    tbl.push_back('{1'b1, 16'h0100, 16'h0008, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0100, 16'h0000, 16'h0000, "csr_unf_clr"});
    tbl.push_back('{1'b1, 16'h0104, 16'h1111, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0104, 16'h0000, 16'hF1F0, "id_ro"});
    tbl.push_back('{1'b1, 16'h0103, 16'hBEEF, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0103, 16'h0000, 16'hBEEF, "pattern_rw"});
    tbl.push_back('{1'b1, 16'h0102, 16'h0055, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0102, 16'h0000, 16'h0000, "count_ro"});
    tbl.push_back('{1'b1, 16'h0207, 16'h0101, 16'h0000, ""});
    tbl.push_back('{1'b0, 16'h0106, 16'h0000, 16'h0000, "rsvd6"});

    do_reset();

    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_write(tbl[i].addr, tbl[i].data);
      else begin
        bus_read(tbl[i].addr, rd);
        chk(tbl[i].name, rd, tbl[i].exp);
      end
    end

    // Fill, overflow, drain; pointers start at 2 so the drain crosses the wrap point.
    for (int i = 0; i < DEPTH; i++) bus_write(16'h0101, 16'(i));
    chk("full_512", 16'(full), 16'h0001);
    bus_read(16'h0102, rd); chk("count_512", rd, 16'h0200);
    bus_write(16'h0101, 16'hFFFF);
    bus_read(16'h0100, rd); chk("csr_ovf", rd, 16'h0004);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(16'h0101, rd); chk("pass1_data", rd, 16'(i));
    end
    bus_write(16'h0100, 16'h0004);
    for (int i = 0; i < DEPTH; i++) bus_write(16'h0101, 16'(i) ^ 16'h5A5A);
    for (int i = 0; i < DEPTH; i++) begin
      bus_read(16'h0101, rd); chk("pass2_data", rd, 16'(i) ^ 16'h5A5A);
    end
    chk("pass2_empty", 16'(empty), 16'h0001);

    // Pattern source fill from 0xFFFE.
    bus_write(16'h0103, 16'hFFFE);
    bus_write(16'h0100, 16'h0002);
    cyc = 0;
    while (!full && cyc < 600) begin
      cycle(1'b0, 1'b0, 16'h0100, 16'h0000);
      cyc++;
    end
    chk("pat_fill_cycles", 16'(cyc), 16'd512);
    bus_read(16'h0103, rd); chk("pat_after_fill", rd, 16'h01FE);
    bus_read(16'h0100, rd); chk("pat_csr_no_ovf", rd, 16'h0002);
    bus_write(16'h0100, 16'h0000);
    bus_read(16'h0101, rd); chk("pat_pop0", rd, 16'hFFFE);
    bus_read(16'h0101, rd); chk("pat_pop1", rd, 16'hFFFF);
    bus_read(16'h0101, rd); chk("pat_pop2", rd, 16'h0000);
    bus_write(16'h0100, 16'h0001);

    // Bus push coinciding with an active pattern source.
    bus_write(16'h0103, 16'h0700);
    bus_write(16'h0100, 16'h0002);
    bus_write(16'h0101, 16'h5555);
    bus_write(16'h0100, 16'h0000);
    bus_read(16'h0103, rd); chk("mix_pattern", rd, 16'h0705);
    bus_read(16'h0102, rd); chk("mix_count", rd, 16'h0006);
    bus_read(16'h0101, rd); chk("mix_d0", rd, 16'h0700);
    bus_read(16'h0101, rd); chk("mix_d1", rd, 16'h0701);
    bus_read(16'h0101, rd); chk("mix_d2", rd, 16'h5555);
    bus_read(16'h0101, rd); chk("mix_d3", rd, 16'h0702);
    bus_read(16'h0101, rd); chk("mix_d4", rd, 16'h0703);
    bus_read(16'h0101, rd); chk("mix_d5", rd, 16'h0704);

    // Flush with 100 words queued.
    bus_write(16'h0103, 16'h4321);
    for (int i = 0; i < 100; i++) bus_write(16'h0101, 16'(i + 7));
    bus_read(16'h0102, rd); chk("pre_flush_count", rd, 16'd100);
    bus_write(16'h0100, 16'h0001);
    chk("flush_empty", 16'(empty), 16'h0001);
    bus_read(16'h0102, rd); chk("flush_count", rd, 16'h0000);
    bus_read(16'h0103, rd); chk("flush_pattern", rd, 16'h4321);
    bus_read(16'h0100, rd); chk("flush_csr", rd, 16'h0000);

    // Random traffic against the model.
    for (int i = 0; i < 1200; i++) begin
      a = ($urandom_range(0, 19) == 0) ? 16'h0200 : BASE;
      a[2:0] = ($urandom_range(0, 1) == 0) ? 3'd1 : 3'($urandom_range(0, 7));
      d = 16'($urandom);
      if (a[2:0] == 3'd0) begin
        d[15:4] = '0;
        d[0] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 1) == 1) bus_write(a, d);
      else bus_read(a, rd);
    end

    // Reset in the middle of a pattern fill.
    bus_write(16'h0100, 16'h0001);
    bus_write(16'h0100, 16'h0002);
    repeat (40) cycle(1'b0, 1'b0, 16'h0102, 16'h0000);
    do_reset();
    bus_read(16'h0100, rd); chk("post_rst_csr", rd, 16'h0000);
    bus_read(16'h0102, rd); chk("post_rst_count", rd, 16'h0000);
    bus_read(16'h0103, rd); chk("post_rst_pattern", rd, 16'h0000);
    bus_read(16'h0101, rd); chk("post_rst_data", rd, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
